// File: rtl/gemm_tile_sequencer.sv
// Per-tile GEMM scheduler: pops one config entry, loads B rows, streams A rows, drains the array, optionally stores C rows.
// Latency: POP 1 cycle, then one row per granted cycle, ARRAY_LAT drain cycles, FIN 1 cycle (done pulse).
// Backpressure: mem_req/mem_addr/mem_we held until mem_gnt; config consumed only from IDLE.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   conf_empty, tile_*  config buffer head (valid when conf_empty=0), msize/ksize/nsize, store, overwrite
//   read_all_buffers    one-cycle pop of the config buffers
//   mem_req/we/addr/gnt single req/gnt row port shared by B loads, A streaming and C stores
//   load_b_en           high while B rows are being requested
//   stream_a_en         high while A rows are being requested
//   acc_clear           one-cycle accumulator clear, coincides with the first STREAM_A cycle
//   ncols               latched, saturated nsize
//   busy, done          not idle / one-cycle tile completion pulse
module gemm_tile_sequencer #(
  parameter int DIM       = 16,
  parameter int ARRAY_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_empty,
  input  logic [31:0] tile_A_addr,
  input  logic [31:0] tile_B_addr,
  input  logic [31:0] tile_C_addr,
  input  logic [31:0] tile_A_stride,
  input  logic [31:0] tile_B_stride,
  input  logic [4:0]  msize,
  input  logic [4:0]  ksize,
  input  logic [4:0]  nsize,
  input  logic        store,
  input  logic        overwrite,
  output logic        read_all_buffers,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  output logic        load_b_en,
  output logic        stream_a_en,
  output logic        acc_clear,
  output logic [4:0]  ncols,
  output logic        busy,
  output logic        done
);

  localparam int             CW     = $clog2(ARRAY_LAT + 1);
  localparam logic [CW-1:0]  LAT    = CW'(ARRAY_LAT);
  localparam logic [4:0]     DIM_SZ = 5'(DIM);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD_B, STREAM_A, DRAIN, STORE, FIN
  } state_t;

  state_t        state;
  logic [31:0]   a_addr, c_addr, a_stride, b_stride;
  logic [4:0]    m_lat, k_lat;
  logic          store_lat, ow_lat;
  logic [4:0]    row;
  logic [CW-1:0] cnt;

  function automatic logic [4:0] sat(input logic [4:0] v);
    return (v > DIM_SZ) ? DIM_SZ : v;
  endfunction

  logic [4:0] m_in, k_in, n_in;
  assign m_in = sat(msize);
  assign k_in = sat(ksize);
  assign n_in = sat(nsize);

  // mem_addr doubles as the running row pointer: it only advances on a
  // grant, so it is naturally stable while a request is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      read_all_buffers <= 1'b0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      load_b_en        <= 1'b0;
      stream_a_en      <= 1'b0;
      acc_clear        <= 1'b0;
      ncols            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      a_addr           <= '0;
      c_addr           <= '0;
      a_stride         <= '0;
      b_stride         <= '0;
      m_lat            <= '0;
      k_lat            <= '0;
      store_lat        <= 1'b0;
      ow_lat           <= 1'b0;
      row              <= '0;
      cnt              <= '0;
    end else begin
      read_all_buffers <= 1'b0;
      acc_clear        <= 1'b0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (!conf_empty) begin
            state            <= POP;
            busy             <= 1'b1;
            read_all_buffers <= 1'b1;
          end
        end

        POP: begin
          a_addr    <= tile_A_addr;
          c_addr    <= tile_C_addr;
          a_stride  <= tile_A_stride;
          b_stride  <= tile_B_stride;
          m_lat     <= m_in;
          k_lat     <= k_in;
          ncols     <= n_in;
          store_lat <= store;
          ow_lat    <= overwrite;
          row       <= '0;
          mem_addr  <= tile_B_addr;
          // Zero sizes skip their phases; an all-zero tile goes straight to FIN.
          if (k_in != 5'd0) begin
            state     <= LOAD_B;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            load_b_en <= 1'b1;
          end else if (m_in != 5'd0) begin
            state       <= STREAM_A;
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= tile_A_addr;
            stream_a_en <= 1'b1;
            acc_clear   <= overwrite;
          end else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end

        LOAD_B: begin
          if (mem_gnt) begin
            if (row == k_lat - 5'd1) begin
              row       <= '0;
              load_b_en <= 1'b0;
              if (m_lat != 5'd0) begin
                // Request stays up: the first A row follows the last B row directly.
                state       <= STREAM_A;
                mem_addr    <= a_addr;
                stream_a_en <= 1'b1;
                acc_clear   <= ow_lat;
              end else begin
                state   <= FIN;
                mem_req <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              row      <= row + 5'd1;
              mem_addr <= mem_addr + b_stride;
            end
          end
        end

        STREAM_A: begin
          if (mem_gnt) begin
            if (row == m_lat - 5'd1) begin
              state       <= DRAIN;
              row         <= '0;
              mem_req     <= 1'b0;
              stream_a_en <= 1'b0;
              cnt         <= LAT;
            end else begin
              row      <= row + 5'd1;
              mem_addr <= mem_addr + a_stride;
            end
          end
        end

        DRAIN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (store_lat) begin
              state    <= STORE;
              mem_addr <= c_addr;
              row      <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end

        STORE: begin
          if (mem_gnt) begin
            if (row == m_lat - 5'd1) begin
              state   <= FIN;
              row     <= '0;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              done    <= 1'b1;
            end else begin
              row      <= row + 5'd1;
              // C rows share the B stride.
              mem_addr <= mem_addr + b_stride;
            end
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer with a transaction-level scoreboard.
// The model lists each tile's expected row requests (phase, we, addr) and its POP-to-done length.
// A negedge monitor checks every granted request and request stability under stalls.
module tb_gemm_tile_sequencer;
  localparam int DIM = 16;
  localparam int LAT = 16;

  logic        clk, rst, conf_empty;
  logic [31:0] tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride, tile_B_stride;
  logic [4:0]  msize, ksize, nsize;
  logic        store, overwrite;
  logic        read_all_buffers, mem_req, mem_we, mem_gnt;
  logic [31:0] mem_addr;
  logic        load_b_en, stream_a_en, acc_clear, busy, done;
  logic [4:0]  ncols;

  gemm_tile_sequencer #(.DIM(DIM), .ARRAY_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .conf_empty(conf_empty),
    .tile_A_addr(tile_A_addr), .tile_B_addr(tile_B_addr), .tile_C_addr(tile_C_addr),
    .tile_A_stride(tile_A_stride), .tile_B_stride(tile_B_stride),
    .msize(msize), .ksize(ksize), .nsize(nsize), .store(store), .overwrite(overwrite),
    .read_all_buffers(read_all_buffers), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .load_b_en(load_b_en),
    .stream_a_en(stream_a_en), .acc_clear(acc_clear), .ncols(ncols),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [1:0]  ph;   // 0 = B read, 1 = A read, 2 = C write
    logic [31:0] addr;
  } txn_t;

  txn_t exp_q[$];
  int errors = 0, checks = 0;
  int cyc = 0;
  int pops = 0, dones = 0, accs = 0;
  int pop_cyc = 0, done_cyc = 0, last_a_cyc = 0, first_w_cyc = 0;
  int stall = 0;
  int last_dur = 0;
  logic [31:0] last_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic int satf(input int v);
    return (v > DIM) ? DIM : v;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Grant driver: hold mem_gnt low for the first 'stall' requesting cycles.
  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && stall > 0) begin
        mem_gnt = 1'b0;
        stall--;
      end else begin
        mem_gnt = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_req, prev_gnt, prev_we;
    logic [31:0] prev_addr;
    txn_t        e;
    prev_req = 0; prev_gnt = 0; prev_we = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0;
      end else begin
        if (prev_req && !prev_gnt) begin
          chk("req_held", {31'd0, mem_req}, 32'd1);
          chk("addr_held", mem_addr, prev_addr);
          chk("we_held", {31'd0, mem_we}, {31'd0, prev_we});
        end
        if (mem_req) chk("busy_during_req", {31'd0, busy}, 32'd1);
        if (mem_req && mem_gnt) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req actual addr=0x%0h we=%0b required no request", mem_addr, mem_we);
          end else begin
            e = exp_q.pop_front();
            chk("req_addr", mem_addr, e.addr);
            chk("req_we", {31'd0, mem_we}, {31'd0, (e.ph == 2'd2)});
            chk("load_b_en", {31'd0, load_b_en}, {31'd0, (e.ph == 2'd0)});
            chk("stream_a_en", {31'd0, stream_a_en}, {31'd0, (e.ph == 2'd1)});
            if (e.ph == 2'd1) last_a_cyc = cyc;
            if (e.ph == 2'd2 && first_w_cyc == 0) first_w_cyc = cyc;
          end
          last_addr = mem_addr;
        end
        if (read_all_buffers) begin pops++; pop_cyc = cyc; end
        if (done) begin dones++; done_cyc = cyc; end
        if (acc_clear) begin
          accs++;
          chk("acc_clear_in_stream", {31'd0, stream_a_en}, 32'd1);
        end
        prev_req = mem_req; prev_gnt = mem_gnt; prev_we = mem_we; prev_addr = mem_addr;
      end
    end
  end

  // Issue one tile, build its expected traffic, wait for done (or reset mid-STREAM_A).
  task automatic run_tile(input logic [31:0] a, b, c, as, bs,
                          input int m, k, n, input logic st, ow,
                          input int stalls, input bit rst_mid);
    int ms, ks, ns, exp_dur, p0, d0, a0, t;
    ms = satf(m); ks = satf(k); ns = satf(n);
    for (int i = 0; i < ks; i++) exp_q.push_back('{ph: 2'd0, addr: b + 32'(i) * bs});
    for (int i = 0; i < ms; i++) exp_q.push_back('{ph: 2'd1, addr: a + 32'(i) * as});
    if (st && ms > 0)
      for (int i = 0; i < ms; i++) exp_q.push_back('{ph: 2'd2, addr: c + 32'(i) * bs});
    exp_dur = 1 + ks + ms + stalls + ((ms > 0) ? (LAT + ((st != 0) ? ms : 0)) : 0);
    p0 = pops; d0 = dones; a0 = accs; first_w_cyc = 0;
    stall = stalls;
    tile_A_addr = a; tile_B_addr = b; tile_C_addr = c;
    tile_A_stride = as; tile_B_stride = bs;
    msize = 5'(m); ksize = 5'(k); nsize = 5'(n); store = st; overwrite = ow;
    conf_empty = 1'b0;
    t = 0;
    while (pops == p0 && t < 50) begin @(posedge clk); #1; t++; end
    conf_empty = 1'b1;
    chk("pop_seen", {31'd0, (pops != p0)}, 32'd1);
    if (rst_mid) begin
      t = 0;
      while (!stream_a_en && t < 100) begin @(posedge clk); #1; t++; end
      chk("reached_stream_a", {31'd0, stream_a_en}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_stream", {31'd0, stream_a_en}, 32'd0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid_no_done", 32'(dones - d0), 32'd0);
      chk("rst_mid_idle", {31'd0, busy}, 32'd0);
    end else begin
      t = 0;
      while (dones == d0 && t < 500) begin @(posedge clk); #1; t++; end
      chk("done_seen", 32'(dones - d0), 32'd1);
      last_dur = done_cyc - pop_cyc;
      chk("tile_len_model", 32'(last_dur), 32'(exp_dur));
      chk("pop_count", 32'(pops - p0), 32'd1);
      chk("acc_count", 32'(accs - a0), {31'd0, (ow && ms > 0)});
      chk("all_rows_issued", 32'(exp_q.size()), 32'd0);
      chk("ncols", {27'd0, ncols}, 32'(ns));
      @(posedge clk); #1;
      chk("idle_after_done", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; conf_empty = 1'b1;
    tile_A_addr = '0; tile_B_addr = '0; tile_C_addr = '0;
    tile_A_stride = '0; tile_B_stride = '0;
    msize = '0; ksize = '0; nsize = '0; store = 0; overwrite = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pop", {31'd0, read_all_buffers}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ncols", {27'd0, ncols}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_req", {31'd0, mem_req}, 32'd0);

    // 1: basic tile with store.
    run_tile(32'h200, 32'h100, 32'h300, 32'h40, 32'h20, 2, 3, 4, 1'b1, 1'b0, 0, 1'b0);
    chk("t1_len", 32'(last_dur), 32'd24);
    chk("t1_drain_gap", 32'(first_w_cyc - last_a_cyc - 1), 32'd16);

    // 2: first request stalled 5 cycles.
    run_tile(32'h200, 32'h100, 32'h300, 32'h40, 32'h20, 2, 3, 4, 1'b1, 1'b0, 5, 1'b0);
    chk("t2_len", 32'(last_dur), 32'd29);

    // 3: no store, overwrite.
    run_tile(32'h200, 32'h100, 32'h300, 32'h40, 32'h20, 2, 3, 4, 1'b0, 1'b1, 0, 1'b0);
    chk("t3_len", 32'(last_dur), 32'd22);

    // 4: all-zero tile, then saturated sizes.
    run_tile(32'h200, 32'h100, 32'h300, 32'h40, 32'h20, 0, 0, 0, 1'b1, 1'b1, 0, 1'b0);
    chk("t4_zero_len", 32'(last_dur), 32'd1);
    run_tile(32'h1000, 32'h8000, 32'h4000, 32'h40, 32'h20, 31, 31, 31, 1'b1, 1'b1, 0, 1'b0);
    chk("t4_sat_len", 32'(last_dur), 32'd65);
    chk("t4_sat_ncols", {27'd0, ncols}, 32'd16);

    // 5: B address wraps.
    run_tile(32'h200, 32'hFFFF_FFE0, 32'h300, 32'h40, 32'h20, 0, 2, 1, 1'b0, 1'b0, 0, 1'b0);
    chk("t5_wrap_addr", last_addr, 32'h0000_0000);
    chk("t5_len", 32'(last_dur), 32'd3);

    // 6: reset in STREAM_A, then a clean tile.
    run_tile(32'h200, 32'h100, 32'h300, 32'h40, 32'h20, 2, 3, 4, 1'b1, 1'b0, 0, 1'b1);
    run_tile(32'h200, 32'h100, 32'h300, 32'h40, 32'h20, 2, 3, 4, 1'b1, 1'b0, 0, 1'b0);
    chk("t6_after_rst_len", 32'(last_dur), 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
